dmem_access_ctrl: RTL and testbench

//  Load/store access controller between the execute stage (ALU address, rs2 data) and data memory.

---
 rtl/dmem_access_ctrl_pkg.sv | 33 +++
 rtl/dmem_store_align.sv | 41 ++++
 rtl/dmem_access_ctrl.sv | 131 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_pkg
// Shared definitions for the data-memory access controller:
//   - SZ_* access size codes (11 is reserved and behaves as a word access)
//   - ds_state_e controller state encoding (IDLE / REQ / DONE)
//   - misaligned(): alignment rule used when misalignment trapping is built in
// -----------------------------------------------------------------------------
package dmem_access_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_REQ  = 2'b01,
        DS_DONE = 2'b10
    } ds_state_e;

    // Bytes never misalign; halves need addr[0]=0; words (and the reserved
    // code) need addr[1:0]=0.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_store_align.sv
// -----------------------------------------------------------------------------
// dmem_store_align
// Combinational store lane steering: byte enables and lane-replicated data.
// Ports:
//   size      in  2   access size code (SZ_*; 11 treated as word)
//   addr_lo   in  2   low byte-address bits
//   wdata     in  32  raw store data (rs2)
//   be        out 4   byte enables for the addressed lanes
//   wdata_rep out 32  store data replicated across all lanes
// -----------------------------------------------------------------------------
module dmem_store_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep
);

    // Replicating the data lets memory pick any lane using only the enables.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// Load/store access controller between execute and data memory. Latches the
// access on req_valid, drives a variable-latency req/ack memory port, stalls
// the PC while the access is in flight and returns the raw aligned word.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses without touching memory).
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/store/size  access request from execute (held until done)
//   req_addr, req_wdata   byte address and store data
//   stall                 hold PC/IF while an access is pending
//   done                  one-cycle completion pulse; rdata/flags valid
//   rdata                 loaded word (0 for stores, errors, traps)
//   bus_err, misalign     completion flags, valid with done
//   mem_req/we/be/addr/wdata, mem_ack, mem_rdata   memory port
// -----------------------------------------------------------------------------
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        bus_err,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    ds_state_e        state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             lat_store;
    logic [3:0]       align_be;
    logic [31:0]      align_wdata;
    logic             trap;
    logic             timeout;

    dmem_store_align u_store_align (
        .size      (req_size),
        .addr_lo   (req_addr[1:0]),
        .wdata     (req_wdata),
        .be        (align_be),
        .wdata_rep (align_wdata)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = misaligned(req_size, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

    // rst is folded in so a reset mid-access drops the request and the stall
    // immediately, without waiting for a clock edge.
    assign mem_req = !rst && (state == DS_REQ);
    assign mem_we  = mem_req && lat_store;
    assign stall   = !rst && (((state == DS_IDLE) && req_valid) || (state == DS_REQ));
    assign done    = (state == DS_DONE);

    always_comb begin
        state_next = state;
        case (state)
            DS_IDLE: if (req_valid) state_next = trap ? DS_DONE : DS_REQ;
            DS_REQ:  if (mem_ack || timeout) state_next = DS_DONE;
            DS_DONE: state_next = DS_IDLE;
            default: state_next = DS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DS_IDLE;
            cnt       <= '0;
            lat_store <= 1'b0;
            rdata     <= '0;
            bus_err   <= 1'b0;
            misalign  <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_next;
            case (state)
                DS_IDLE: begin
                    if (req_valid) begin
                        lat_store <= req_store;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= req_store ? align_be : 4'b1111;
                        mem_wdata <= req_store ? align_wdata : 32'h0;
                        cnt       <= '0;
                        if (trap) begin
                            misalign <= 1'b1;
                            rdata    <= '0;
                        end
                    end
                end
                DS_REQ: begin
                    if (!(&cnt)) cnt <= cnt + 1'b1;
                    if (mem_ack) begin
                        rdata <= lat_store ? 32'h0 : mem_rdata;
                    end else if (timeout) begin
                        bus_err <= 1'b1;
                        rdata   <= '0;
                    end
                end
                DS_DONE: begin
                    bus_err  <= 1'b0;
                    misalign <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 16;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall, done, bus_err, misalign;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    dmem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_store (req_store),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .bus_err   (bus_err),
        .misalign  (misalign),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic model_trap(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (!TRAP_EN) return 1'b0;
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (off % 2) != 0;
        return off != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic st, input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (!st) return 4'hF;
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d % 256) * 32'h01010101;
        if (sz == 2'd1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    // One complete access: drives the request, acts as the memory (ack after
    // ack_delay extra REQ cycles) and compares against the model inline.
    task automatic run_access(input logic st, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] d, input int ack_delay, input logic [31:0] rd,
                              input logic drop_valid, input string name);
        logic        trap, exp_berr;
        int          exp_reqs, reqs, cyc;
        logic [31:0] exp_rdata;
        trap      = model_trap(sz, a);
        exp_berr  = !trap && (ack_delay >= TIMEOUT);
        exp_reqs  = trap ? 0 : ((ack_delay < TIMEOUT) ? ack_delay + 1 : TIMEOUT);
        exp_rdata = (trap || st || exp_berr) ? 32'h0 : rd;

        req_valid = 1'b1; req_store = st; req_size = sz; req_addr = a; req_wdata = d;
        mem_ack = 1'b0; mem_rdata = rd;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL %s_stall_idle got %0b want 1", name, stall); end
        @(negedge clk);
        reqs = 0; cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (mem_req === 1'b1) begin
                if (reqs == 0) begin
                    checks++;
                    if (mem_addr !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL %s_addr got %h want %h", name, mem_addr, a & 32'hFFFF_FFFC); end
                    checks++;
                    if (mem_be !== model_be(st, sz, a)) begin errors++; $display("FAIL %s_be got %b want %b", name, mem_be, model_be(st, sz, a)); end
                    checks++;
                    if (mem_we !== st) begin errors++; $display("FAIL %s_we got %0b want %0b", name, mem_we, st); end
                    checks++;
                    if (stall !== 1'b1) begin errors++; $display("FAIL %s_stall_req got %0b want 1", name, stall); end
                    if (st) begin
                        checks++;
                        if (mem_wdata !== model_wdata(sz, d)) begin errors++; $display("FAIL %s_wdata got %h want %h", name, mem_wdata, model_wdata(sz, d)); end
                    end
                end
                reqs++;
                if (drop_valid && reqs == 1) req_valid = 1'b0;
            end
            mem_ack = (mem_req === 1'b1) && (reqs == ack_delay + 1);
            @(negedge clk);
            cyc++;
        end
        mem_ack = 1'b0;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL %s_done got %0b want 1 (timed out)", name, done); end
        checks++;
        if (reqs !== exp_reqs || cyc !== exp_reqs) begin errors++; $display("FAIL %s_req_cycles got %0d/%0d want %0d", name, reqs, cyc, exp_reqs); end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL %s_rdata got %h want %h", name, rdata, exp_rdata); end
        checks++;
        if (bus_err !== exp_berr) begin errors++; $display("FAIL %s_bus_err got %0b want %0b", name, bus_err, exp_berr); end
        checks++;
        if (misalign !== trap) begin errors++; $display("FAIL %s_misalign got %0b want %0b", name, misalign, trap); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL %s_stall_done got %0b want 0", name, stall); end
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || bus_err !== 1'b0 || misalign !== 1'b0) begin
            errors++; $display("FAIL %s_after_done got done=%0b berr=%0b mis=%0b want 0", name, done, bus_err, misalign);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({stall, done, mem_req, mem_we, bus_err, misalign} !== 6'b0 || mem_be !== 4'h0 ||
            rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_state got stall=%0b done=%0b req=%0b be=%h rdata=%h addr=%h wdata=%h want all 0",
                               stall, done, mem_req, mem_be, rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        // ack with nothing pending must be ignored
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL stray_ack got done=%0b req=%0b stall=%0b want 0", done, mem_req, stall);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_directed();
        run_access(1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 0, 32'h5555_AAAA, 1'b0, "sw");
        run_access(1'b1, 2'b00, 32'h103, 32'h12345678, 1, 32'h0, 1'b0, "sb");
        run_access(1'b0, 2'b10, 32'h200, 32'h0, 3, 32'hCAFEF00D, 1'b0, "lw_wait");
        run_access(1'b0, 2'b10, 32'h300, 32'h0, 1000, 32'h1234_5678, 1'b0, "lw_timeout");
        run_access(1'b0, 2'b01, 32'h101, 32'h0, 0, 32'hA5A5_5A5A, 1'b0, "lh_odd");
        run_access(1'b1, 2'b01, 32'h102, 32'hFFFF_BEEF, 2, 32'h0, 1'b1, "sh_drop");
        run_access(1'b1, 2'b11, 32'h104, 32'h0BAD_F00D, 0, 32'h0, 1'b0, "s_resv");
    endtask

    task automatic test_reset_mid_access();
        int cyc;
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_addr = 32'h400;
        mem_ack = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (mem_req !== 1'b1 && cyc < 5) begin @(negedge clk); cyc++; end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rst_mid got req=%0b stall=%0b want 0", mem_req, stall);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle got done=%0b req=%0b want 0", done, mem_req);
        end
        run_access(1'b0, 2'b10, 32'h404, 32'h0, 1, 32'h0F0F_1234, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int r;
            int dly;
            r   = int'($urandom_range(0, 7));
            dly = (r == 7) ? TIMEOUT + 2 : r;
            run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                       dly, $urandom, ($urandom_range(0, 3) == 0), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
